// File: rtl/wb_dma_defs.sv
// Shared definitions for the Wishbone word-copy DMA engine:
// FSM state encodings, default abort timeout and address stride.
package wb_dma_defs;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RGAP,
        S_WRITE,
        S_STEP,
        S_DONE
    } state_t;

    localparam int          DEF_TIMEOUT = 255;
    localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

// File: rtl/wb_dma_copy.sv
// Wishbone classic master that copies len words from src to dst,
// one read/write pair per word, aborting on a stalled slave.
module wb_dma_copy
    import wb_dma_defs::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] src_i,
    input  logic [31:0] dst_i,
    input  logic [11:0] len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [11:0] count_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic        wb_we_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    localparam int          TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t        state;
    logic [31:0]   src_q;
    logic [31:0]   dst_q;
    logic [11:0]   len_q;
    logic [31:0]   data_q;
    logic [11:0]   count_q;
    logic          err_q;
    logic [TW-1:0] tmo_q;
    logic [31:0]   offset;

    assign offset = WORD_STRIDE * {20'd0, count_q};

    // Bus outputs decode from the state register only, so an async
    // reset into IDLE drops cyc/stb without waiting for a clock edge.
    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        wb_we_o  = 1'b0;
        wb_adr_o = 32'd0;
        wb_dat_o = 32'd0;
        unique case (state)
            S_READ: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_adr_o = src_q + offset;
            end
            S_WRITE: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = dst_q + offset;
                wb_dat_o = data_q;
            end
            S_RGAP, S_STEP: wb_cyc_o = 1'b1;
            default: ;
        endcase
    end

    assign wb_sel_o = wb_stb_o ? 4'hF : 4'h0;
    assign busy_o   = (state != S_IDLE);
    assign done_o   = (state == S_DONE);
    assign err_o    = err_q;
    assign count_o  = count_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        src_q   <= src_i;
                        dst_q   <= dst_i;
                        len_q   <= len_i;
                        count_q <= '0;
                        err_q   <= 1'b0;
                        tmo_q   <= '0;
                        state   <= (len_i == 12'd0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (wb_ack_i) begin
                        data_q <= wb_dat_i;
                        tmo_q  <= '0;
                        state  <= S_RGAP;
                    end else if (tmo_q == TMAX) begin
                        err_q <= 1'b1;
                        tmo_q <= '0;
                        state <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_RGAP: state <= S_WRITE;
                S_WRITE: begin
                    if (wb_ack_i) begin
                        tmo_q <= '0;
                        state <= S_STEP;
                    end else if (tmo_q == TMAX) begin
                        err_q <= 1'b1;
                        tmo_q <= '0;
                        state <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_STEP: begin
                    count_q <= count_q + 12'd1;
                    state   <= ((count_q + 12'd1) < len_q) ? S_READ : S_DONE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dma_copy.sv
// Scoreboard bench for wb_dma_copy against a small Wishbone RAM
// that acks on the second strobe cycle.
module tb_wb_dma_copy;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] src_i = '0;
    logic [31:0] dst_i = '0;
    logic [11:0] len_i = '0;
    logic        busy_o, done_o, err_o;
    logic [11:0] count_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o, wb_cyc_o, wb_we_o;
    logic        wb_ack_i = 1'b0;

    wb_dma_copy #(.TIMEOUT(255)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .src_i(src_i), .dst_i(dst_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .count_o(count_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_we_o(wb_we_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Block RAM slave: 256 words, registered ack on 2nd strobe cycle
    logic [31:0] mem [0:255];
    logic        ack_en = 1'b1;
    logic        tb_we = 1'b0;
    logic        tb_clr = 1'b0;
    logic [7:0]  tb_wa = '0;
    logic [31:0] tb_wd = '0;
    wire  [7:0]  ridx = wb_adr_o[9:2];

    assign wb_dat_i = mem[ridx];

    always @(posedge clk_i) begin
        wb_ack_i <= wb_cyc_o && wb_stb_o && ack_en && !wb_ack_i;
        if (tb_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (tb_we) begin
            mem[tb_wa] <= tb_wd;
        end else if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i) begin
            mem[ridx] <= wb_dat_o;
        end
    end

    int ncyc = 0;
    always @(posedge clk_i) ncyc++;

    typedef struct {
        int          lat;
        logic [11:0] cnt;
        logic        err;
        int          stbs;
    } done_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    done_t       exp_done[$];
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];

    int checks = 0;
    int errors = 0;
    int start_cyc = 0;
    int stb_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every bus beat and completion pulse to the queues
    always @(negedge clk_i) begin
        if (!rst_i) begin
            stb_cnt = 0;
        end else begin
            if (wb_stb_o) stb_cnt++;
            if (wb_stb_o && wb_ack_i && !wb_we_o) begin
                if (exp_rd.size() == 0) begin
                    chk("unexpected_read", wb_adr_o, 32'hFFFF_FFFF);
                end else begin
                    chk("read_adr", wb_adr_o, exp_rd.pop_front());
                    chk("read_sel", {28'd0, wb_sel_o}, 32'hF);
                end
            end
            if (wb_stb_o && wb_ack_i && wb_we_o) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", wb_adr_o, 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("write_adr", wb_adr_o, w.adr);
                    chk("write_dat", wb_dat_o, w.dat);
                    chk("write_sel", {28'd0, wb_sel_o}, 32'hF);
                end
            end
            if (done_o) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("done_latency", ncyc - start_cyc, d.lat);
                    chk("done_count", {20'd0, count_o}, {20'd0, d.cnt});
                    chk("done_err", {31'd0, err_o}, {31'd0, d.err});
                    chk("stb_cycles", stb_cnt, d.stbs);
                end
                stb_cnt = 0;
            end
        end
    end

    task automatic ram_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_i);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        @(negedge clk_i);
        tb_we = 1'b0;
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d,
                              input logic [11:0] n);
        @(negedge clk_i);
        src_i = s;
        dst_i = d;
        len_i = n;
        start_i = 1'b1;
        start_cyc = ncyc;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done_o && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        if (!done_o) chk({name, "_done_timeout"}, 32'd0, 32'd1);
        @(negedge clk_i);
        chk({name, "_busy_after"}, {31'd0, busy_o}, 32'd0);
        chk({name, "_cyc_after"}, {31'd0, wb_cyc_o}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
        chk({name, "_stb"}, {31'd0, wb_stb_o}, 32'd0);
        chk({name, "_we"}, {31'd0, wb_we_o}, 32'd0);
        chk({name, "_sel"}, {28'd0, wb_sel_o}, 32'd0);
        chk({name, "_adr"}, wb_adr_o, 32'd0);
        chk({name, "_dat"}, wb_dat_o, 32'd0);
        chk({name, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({name, "_done"}, {31'd0, done_o}, 32'd0);
        chk({name, "_err"}, {31'd0, err_o}, 32'd0);
        chk({name, "_count"}, {20'd0, count_o}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk_i);
        tb_clr = 1'b1;
        @(negedge clk_i);
        tb_clr = 1'b0;
        chk_reset_outputs("reset");
        ram_wr(8'd0, 32'd1);
        ram_wr(8'd1, 32'd2);
        ram_wr(8'd2, 32'd3);
        ram_wr(8'd3, 32'd4);
        for (int i = 0; i < 4; i++) ram_wr(8'(16 + i), 32'hA0 + i);
        ram_wr(8'd128, 32'hDEAD_0001);
        ram_wr(8'd255, 32'h55);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Basic 4-word copy 0x000 -> 0x100
        for (int i = 0; i < 4; i++) begin
            exp_rd.push_back(32'(4 * i));
            exp_wr.push_back('{32'h100 + 32'(4 * i), 32'(i + 1)});
        end
        exp_done.push_back('{25, 12'd4, 1'b0, 16});
        start_copy(32'h0, 32'h100, 12'd4);
        wait_done("copy4");
        for (int i = 0; i < 4; i++)
            chk("ram_copy4", mem[64 + i], 32'(i + 1));

        // Zero-length copy
        exp_done.push_back('{1, 12'd0, 1'b0, 0});
        start_copy(32'h0, 32'h200, 12'd0);
        wait_done("len0");

        // Stalled slave: abort after TIMEOUT strobe cycles
        ack_en = 1'b0;
        exp_done.push_back('{256, 12'd0, 1'b1, 255});
        start_copy(32'h0, 32'h3C0, 12'd2);
        wait_done("timeout");
        chk("err_sticky", {31'd0, err_o}, 32'd1);
        ack_en = 1'b1;

        // Second start mid-copy is ignored
        for (int i = 0; i < 4; i++) begin
            exp_rd.push_back(32'h40 + 32'(4 * i));
            exp_wr.push_back('{32'h140 + 32'(4 * i), 32'hA0 + 32'(i)});
        end
        exp_done.push_back('{25, 12'd4, 1'b0, 16});
        start_copy(32'h40, 32'h140, 12'd4);
        repeat (6) @(negedge clk_i);
        src_i = 32'h200;
        dst_i = 32'h240;
        len_i = 12'd1;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done("restart");
        for (int i = 0; i < 4; i++)
            chk("ram_restart", mem[80 + i], 32'hA0 + 32'(i));
        chk("ram_restart_untouched", mem[144], 32'd0);

        // Reset during second write: only the first word lands
        exp_rd.push_back(32'h0);
        exp_rd.push_back(32'h4);
        exp_wr.push_back('{32'h300, 32'd1});
        start_copy(32'h0, 32'h300, 12'd4);
        n = 0;
        while (!(wb_stb_o && wb_we_o && wb_adr_o == 32'h304) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("second_write_seen", {31'd0, wb_stb_o && wb_we_o}, 32'd1);
        #1 rst_i = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(negedge clk_i);
        chk_reset_outputs("midreset_hold");
        chk("ram_midreset_w0", mem[192], 32'd1);
        chk("ram_midreset_w1", mem[193], 32'd0);

        // Release reset and start on the very first edge; address wraps
        exp_rd.push_back(32'hFFFF_FFFC);
        exp_rd.push_back(32'h0);
        exp_wr.push_back('{32'h380, 32'h55});
        exp_wr.push_back('{32'h384, 32'd1});
        exp_done.push_back('{13, 12'd2, 1'b0, 8});
        @(negedge clk_i);
        rst_i = 1'b1;
        src_i = 32'hFFFF_FFFC;
        dst_i = 32'h380;
        len_i = 12'd2;
        start_i = 1'b1;
        start_cyc = ncyc;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done("wrap");
        chk("ram_wrap_w0", mem[224], 32'h55);
        chk("ram_wrap_w1", mem[225], 32'd1);

        repeat (3) @(negedge clk_i);
        chk("pending_reads", exp_rd.size(), 0);
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_done", exp_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
